fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Sequences a shared multiply-accumulate engine across both audio channels and all FIR filter bands. Sits between the interpolator output strobes and the FIR MAC datapath, queues left/right sample requests, and walks filter and tap indices one MAC per clock. Emits per-channel done strobes once the MAC pipeline has drained.

## Interface
- NUM_FILTERS, 4, number of filter bands processed per sample (outer loop)
- TAP_W, 9, width of tap count and tap address
- MAC_LATENCY, 3, MAC pipeline depth in clocks (≥1)
- FSEL_W, 2, width of filter_sel (≥ clog2(NUM_FILTERS), minimum 1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  audio enable; low = synchronous abort/hold idle
- coefs_per_tap  in  TAP_W  taps per filter (N), latched at job start
- l_req  in  1  left sample-ready strobe
- r_req  in  1  right sample-ready strobe
- busy  out  1  high whenever the FSM is not IDLE
- mac_en  out  1  issue one MAC this cycle
- mac_clr  out  1  first tap of a filter; accumulator loads instead of adds
- mac_chan  out  1  0 = left, 1 = right
- filter_sel  out  FSEL_W  filter index of the issued MAC
- tap_addr  out  TAP_W  coefficient/history tap index of the issued MAC
- l_done  out  1  one-cycle strobe: left results valid
- r_done  out  1  one-cycle strobe: right results valid
- overrun  out  1  sticky: request arrived with the same channel already pending

## Operation
- Pending flags l_pend/r_pend: set by the corresponding req and cleared when the job starts. A req while its pend is already set sets overrun; the requests merge and only one job runs.
- A req for the channel currently executing sets its pend and queues a new job. This is not an overrun.
- FSM states:
  - IDLE: if l_pend, start L; else if r_pend, start R; else stay. Simultaneous pend gives left priority.
  - On start: latch N = coefs_per_tap, clear that pend, filter=0, tap=0, then go to RUN. If N==0, go directly to DRAIN.
  - RUN: mac_en=1 every cycle. tap increments; at tap==N-1 it wraps to 0 and filter increments. Leave after filter==NUM_FILTERS-1 and tap==N-1.
  - mac_clr=1 when tap==0.
  - DRAIN: lasts MAC_LATENCY cycles with mac_en=0. The done strobe for the job channel pulses in the last DRAIN cycle. Next state is IDLE.
- mac_chan, filter_sel and tap_addr are registered and meaningful only when mac_en=1. They hold their last values otherwise.
- coefs_per_tap changes mid-job are ignored until the next start.
- run low on any edge: FSM goes to IDLE; pends and overrun clear; mac_en, mac_clr and done go low; the aborted job produces no done. Reqs are ignored while run is low.
- Reset values: all outputs 0, FSM IDLE, pends 0, counters 0.

## Timing
- Cycle 0: req high. Cycle 1: pend set, FSM in IDLE. Cycles 2 to NUM_FILTERS·N+1: RUN. Then DRAIN for MAC_LATENCY cycles.
- Done strobe arrives at cycle NUM_FILTERS·N + MAC_LATENCY + 1 after the req cycle (N>0).
- Back-to-back jobs: period NUM_FILTERS·N + MAC_LATENCY + 1 cycles, with one IDLE cycle between jobs.
- N==0: done arrives at cycle MAC_LATENCY + 1 after req, with no mac_en.
- All outputs are registered; there is no combinational path from req to any output.
- A req asserted in the same cycle as the FSM start for that channel is captured into pend and is not lost. A set and a clear of the same pend in one cycle resolve to set.

## Test plan
- Single L, defaults, N=8, req in cycle 0:
  - mac_en high in cycles 2–33 (32 cycles), mac_chan=0.
  - mac_clr high in cycles 2, 10, 18, 26.
  - filter_sel steps 0→3; tap_addr runs 0..7 per filter.
  - l_done only in cycle 36; busy high in cycles 2–36.
- l_req and r_req together in cycle 0, N=8:
  - L job first, l_done in cycle 36.
  - IDLE in cycle 37; R RUN in cycles 38–69 with mac_chan=1; r_done in cycle 72; overrun stays 0.
- Overrun: r_req in cycle 0, l_req in cycle 1, and l_req again in cycle 5 while the L job is still pending behind R:
  - overrun=1 from cycle 6.
  - Only one L job runs.
- Abort: run driven low in cycle 15 of an L job:
  - mac_en=0 and busy=0 from cycle 16.
  - No l_done; overrun cleared.
  - After run returns high, a new req completes normally.
- N=0 with l_req in cycle 0: no mac_en; l_done in cycle 4.
- Async reset pulse mid-RUN: all outputs are 0 immediately, with no waiting for clk.
- Sweep N=1 and N=511 with NUM_FILTERS=4:
  - mac_clr on every mac_en when N=1.
  - For N=511, the final MAC has tap_addr=510 and filter_sel=3.

Source files
------------

// File: rtl/fir_mac_scheduler_if.sv
// Bus between the FIR MAC scheduler and its surroundings.
//   run, coefs_per_tap, l_req, r_req : requests/config into the scheduler
//   busy, mac_en, mac_clr, mac_chan,
//   filter_sel, tap_addr             : MAC issue stream out of the scheduler
//   l_done, r_done, overrun          : completion strobes and sticky error
// slave = scheduler side, master = requester/datapath side.
interface fir_mac_scheduler_if #(
  parameter int unsigned TAP_W  = 9,
  parameter int unsigned FSEL_W = 2
);
  logic              run;
  logic [TAP_W-1:0]  coefs_per_tap;
  logic              l_req;
  logic              r_req;
  logic              busy;
  logic              mac_en;
  logic              mac_clr;
  logic              mac_chan;
  logic [FSEL_W-1:0] filter_sel;
  logic [TAP_W-1:0]  tap_addr;
  logic              l_done;
  logic              r_done;
  logic              overrun;

  modport slave (
    input  run, coefs_per_tap, l_req, r_req,
    output busy, mac_en, mac_clr, mac_chan, filter_sel, tap_addr,
           l_done, r_done, overrun
  );

  modport master (
    output run, coefs_per_tap, l_req, r_req,
    input  busy, mac_en, mac_clr, mac_chan, filter_sel, tap_addr,
           l_done, r_done, overrun
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Shares one MAC engine between left/right channels and all FIR bands.
// Queues per-channel sample requests, then issues one MAC per clock walking
// filter (outer) and tap (inner) indices, drains the MAC pipeline and pulses
// the channel's done strobe.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : run/config/requests in; MAC issue stream, done, overrun out
module fir_mac_scheduler #(
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned TAP_W       = 9,
  parameter int unsigned MAC_LATENCY = 3,
  parameter int unsigned FSEL_W      = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  fir_mac_scheduler_if.slave  bus
);

  localparam int unsigned DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [FSEL_W-1:0]  LAST_FILTER = FSEL_W'(NUM_FILTERS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN  = DRAIN_W'(MAC_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TAP_W-1:0]    n_q, n_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [FSEL_W-1:0]   filt_q, filt_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                chan_q, chan_d;
  logic                l_pend_q, l_pend_d;
  logic                r_pend_q, r_pend_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic                mac_en_q, mac_en_d;
  logic                mac_clr_q, mac_clr_d;
  logic                mac_chan_q, mac_chan_d;
  logic [FSEL_W-1:0]   filter_sel_q, filter_sel_d;
  logic [TAP_W-1:0]    tap_addr_q, tap_addr_d;
  logic                l_done_q, l_done_d;
  logic                r_done_q, r_done_d;
  logic                start_l, start_r;

  // Next-state, queueing and registered-output logic. Outputs are derived
  // from the next state so that they line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    tap_d        = tap_q;
    filt_d       = filt_q;
    drain_d      = drain_q;
    chan_d       = chan_q;
    l_pend_d     = l_pend_q;
    r_pend_d     = r_pend_q;
    overrun_d    = overrun_q;
    start_l      = 1'b0;
    start_r      = 1'b0;
    busy_d       = 1'b0;
    mac_en_d     = 1'b0;
    mac_clr_d    = 1'b0;
    mac_chan_d   = mac_chan_q;
    filter_sel_d = filter_sel_q;
    tap_addr_d   = tap_addr_q;
    l_done_d     = 1'b0;
    r_done_d     = 1'b0;

    if (!bus.run) begin
      // Abort: drop the job and everything queued.
      state_d   = ST_IDLE;
      l_pend_d  = 1'b0;
      r_pend_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (l_pend_q) begin
            start_l = 1'b1;
            chan_d  = 1'b0;
          end else if (r_pend_q) begin
            start_r = 1'b1;
            chan_d  = 1'b1;
          end
          if (start_l || start_r) begin
            n_d     = bus.coefs_per_tap;
            tap_d   = '0;
            filt_d  = '0;
            drain_d = '0;
            state_d = (bus.coefs_per_tap == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (tap_q == (n_q - TAP_W'(1))) begin
            tap_d = '0;
            if (filt_q == LAST_FILTER) begin
              drain_d = '0;
              state_d = ST_DRAIN;
            end else begin
              filt_d = filt_q + FSEL_W'(1);
            end
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == LAST_DRAIN) begin
            state_d = ST_IDLE;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A request coinciding with its own job start is a fresh job, not a merge.
      overrun_d = overrun_q
                | (bus.l_req & l_pend_q & ~start_l)
                | (bus.r_req & r_pend_q & ~start_r);
      l_pend_d  = (l_pend_q & ~start_l) | bus.l_req;
      r_pend_d  = (r_pend_q & ~start_r) | bus.r_req;
    end

    busy_d    = (state_d != ST_IDLE);
    mac_en_d  = (state_d == ST_RUN);
    mac_clr_d = mac_en_d && (tap_d == '0);
    if (mac_en_d) begin
      mac_chan_d   = chan_d;
      filter_sel_d = filt_d;
      tap_addr_d   = tap_d;
    end
    l_done_d = (state_d == ST_DRAIN) && (drain_d == LAST_DRAIN) && !chan_d;
    r_done_d = (state_d == ST_DRAIN) && (drain_d == LAST_DRAIN) &&  chan_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      tap_q        <= '0;
      filt_q       <= '0;
      drain_q      <= '0;
      chan_q       <= 1'b0;
      l_pend_q     <= 1'b0;
      r_pend_q     <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_chan_q   <= 1'b0;
      filter_sel_q <= '0;
      tap_addr_q   <= '0;
      l_done_q     <= 1'b0;
      r_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      tap_q        <= tap_d;
      filt_q       <= filt_d;
      drain_q      <= drain_d;
      chan_q       <= chan_d;
      l_pend_q     <= l_pend_d;
      r_pend_q     <= r_pend_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      mac_en_q     <= mac_en_d;
      mac_clr_q    <= mac_clr_d;
      mac_chan_q   <= mac_chan_d;
      filter_sel_q <= filter_sel_d;
      tap_addr_q   <= tap_addr_d;
      l_done_q     <= l_done_d;
      r_done_q     <= r_done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.mac_chan   = mac_chan_q;
  assign bus.filter_sel = filter_sel_q;
  assign bus.tap_addr   = tap_addr_q;
  assign bus.l_done     = l_done_q;
  assign bus.r_done     = r_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: a job-level reference model
// (elapsed-cycle index per job) checked every cycle, directed scenarios with
// literal cycle expectations, then randomized traffic.
module tb_fir_mac_scheduler;
  localparam int unsigned NF = 4;
  localparam int unsigned TW = 9;
  localparam int unsigned ML = 3;
  localparam int unsigned FW = 2;
  localparam int          AW = 2100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fir_mac_scheduler_if #(.TAP_W(TW), .FSEL_W(FW)) bus();

  fir_mac_scheduler #(
    .NUM_FILTERS(NF), .TAP_W(TW), .MAC_LATENCY(ML), .FSEL_W(FW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: a job occupies elapsed cycles k = 0 .. NF*N+ML-1
  // (MACs while k < NF*N, then pipeline drain), followed by one idle cycle.
  bit m_act, m_chan, m_pl, m_pr, m_ovr, m_sl, m_sr;
  int m_k, m_n;
  bit e_busy, e_en, e_clr, e_chan, e_ld, e_rd;
  int e_fsel, e_tap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 0; m_chan = 0; m_pl = 0; m_pr = 0; m_ovr = 0; m_k = 0; m_n = 0;
      e_busy = 0; e_en = 0; e_clr = 0; e_chan = 0; e_ld = 0; e_rd = 0;
      e_fsel = 0; e_tap = 0;
    end else begin
      if (!bus.run) begin
        m_act = 0; m_pl = 0; m_pr = 0; m_ovr = 0;
      end else begin
        m_sl = 0; m_sr = 0;
        if (m_act) begin
          m_k++;
          if (m_k == int'(NF) * m_n + int'(ML)) m_act = 0;
        end else if (m_pl || m_pr) begin
          m_sl = m_pl;
          m_sr = !m_pl;
          m_act = 1; m_k = 0; m_chan = m_sr; m_n = int'(bus.coefs_per_tap);
        end
        if ((bus.l_req && m_pl && !m_sl) || (bus.r_req && m_pr && !m_sr)) m_ovr = 1;
        m_pl = (m_pl && !m_sl) || bus.l_req;
        m_pr = (m_pr && !m_sr) || bus.r_req;
      end
      e_busy = m_act;
      e_en   = m_act && (m_k < int'(NF) * m_n);
      if (e_en) begin
        e_fsel = m_k / m_n;
        e_tap  = m_k % m_n;
        e_chan = m_chan;
      end
      e_clr = e_en && (e_tap == 0);
      e_ld  = m_act && (m_k == int'(NF) * m_n + int'(ML) - 1) && !m_chan;
      e_rd  = m_act && (m_k == int'(NF) * m_n + int'(ML) - 1) &&  m_chan;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy",    longint'(bus.busy),    longint'(e_busy));
      check("mac_en",  longint'(bus.mac_en),  longint'(e_en));
      check("mac_clr", longint'(bus.mac_clr), longint'(e_clr));
      check("l_done",  longint'(bus.l_done),  longint'(e_ld));
      check("r_done",  longint'(bus.r_done),  longint'(e_rd));
      check("overrun", longint'(bus.overrun), longint'(m_ovr));
      if (e_en) begin
        check("mac_chan",   longint'(bus.mac_chan),   longint'(e_chan));
        check("filter_sel", longint'(bus.filter_sel), longint'(e_fsel));
        check("tap_addr",   longint'(bus.tap_addr),   longint'(e_tap));
      end
    end
  end

  // Per-scenario observations, indexed by cycle relative to the first request.
  bit en_at [AW];
  bit busy_at [AW];
  bit ovr_at [AW];
  int en_first, en_last, en_cnt, en_r_cnt, en_r_first, en_r_last;
  int clr_cnt, clr_first, clr_last, ld_cnt, ld_first, rd_cnt, rd_first;
  int ovr_first, busy_first, busy_last, last_fsel, last_tap;

  task automatic clear_stats();
    for (int i = 0; i < AW; i++) begin
      en_at[i] = 0; busy_at[i] = 0; ovr_at[i] = 0;
    end
    en_first = -1; en_last = -1; en_cnt = 0; en_r_cnt = 0; en_r_first = -1; en_r_last = -1;
    clr_cnt = 0; clr_first = -1; clr_last = -1; ld_cnt = 0; ld_first = -1;
    rd_cnt = 0; rd_first = -1; ovr_first = -1; busy_first = -1; busy_last = -1;
    last_fsel = -1; last_tap = -1;
  endtask

  task automatic sample(input int r);
    if (r < AW) begin
      en_at[r] = bus.mac_en; busy_at[r] = bus.busy; ovr_at[r] = bus.overrun;
    end
    if (bus.mac_en) begin
      en_cnt++;
      if (en_first < 0) en_first = r;
      en_last = r;
      last_fsel = int'(bus.filter_sel);
      last_tap  = int'(bus.tap_addr);
      if (bus.mac_chan) begin
        en_r_cnt++;
        if (en_r_first < 0) en_r_first = r;
        en_r_last = r;
      end
    end
    if (bus.mac_clr) begin
      clr_cnt++;
      if (clr_first < 0) clr_first = r;
      clr_last = r;
    end
    if (bus.l_done) begin
      ld_cnt++;
      if (ld_first < 0) ld_first = r;
    end
    if (bus.r_done) begin
      rd_cnt++;
      if (rd_first < 0) rd_first = r;
    end
    if (bus.overrun && ovr_first < 0) ovr_first = r;
    if (bus.busy) begin
      if (busy_first < 0) busy_first = r;
      busy_last = r;
    end
  endtask

  // Runs n cycles, pulsing requests at the given relative cycles (-1 = none)
  // and optionally holding run low for two cycles from run_lo.
  task automatic watch(input int n, input int l1, input int l2,
                       input int r1, input int r2, input int run_lo);
    clear_stats();
    for (int r = 0; r < n; r++) begin
      @(posedge clk); #2;
      if (r == 0) c0 = cyc;
      bus.l_req = (r == l1) || (r == l2);
      bus.r_req = (r == r1) || (r == r2);
      if (run_lo >= 0 && r == run_lo)     bus.run = 1'b0;
      if (run_lo >= 0 && r == run_lo + 2) bus.run = 1'b1;
      @(negedge clk);
      sample(r);
    end
    bus.l_req = 1'b0;
    bus.r_req = 1'b0;
  endtask

  task automatic quiesce();
    @(posedge clk); #2; bus.run = 1'b0;
    @(posedge clk); #2; bus.run = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       longint'(bus.busy),       0);
    check({tag, "_mac_en"},     longint'(bus.mac_en),     0);
    check({tag, "_mac_clr"},    longint'(bus.mac_clr),    0);
    check({tag, "_mac_chan"},   longint'(bus.mac_chan),   0);
    check({tag, "_filter_sel"}, longint'(bus.filter_sel), 0);
    check({tag, "_tap_addr"},   longint'(bus.tap_addr),   0);
    check({tag, "_l_done"},     longint'(bus.l_done),     0);
    check({tag, "_r_done"},     longint'(bus.r_done),     0);
    check({tag, "_overrun"},    longint'(bus.overrun),    0);
  endtask

  initial begin
    bus.run = 1'b0; bus.l_req = 1'b0; bus.r_req = 1'b0; bus.coefs_per_tap = TW'(8);
    #3;
    check_all_zero("reset");
    #4 reset_n = 1'b1;
    quiesce();

    // Single left job, N=8.
    watch(40, 0, -1, -1, -1, -1);
    check("t1_en_first", en_first, 2);
    check("t1_en_last", en_last, 33);
    check("t1_en_cnt", en_cnt, 32);
    check("t1_chan_r", en_r_cnt, 0);
    check("t1_clr_cnt", clr_cnt, 4);
    check("t1_clr_first", clr_first, 2);
    check("t1_clr_last", clr_last, 26);
    check("t1_last_fsel", last_fsel, 3);
    check("t1_last_tap", last_tap, 7);
    check("t1_ld_first", ld_first, 36);
    check("t1_ld_cnt", ld_cnt, 1);
    check("t1_busy_first", busy_first, 2);
    check("t1_busy_last", busy_last, 36);

    // Simultaneous left and right requests.
    quiesce();
    watch(76, 0, -1, 0, -1, -1);
    check("t2_ld_first", ld_first, 36);
    check("t2_idle37", busy_at[37], 0);
    check("t2_r_first", en_r_first, 38);
    check("t2_r_last", en_r_last, 69);
    check("t2_r_cnt", en_r_cnt, 32);
    check("t2_rd_first", rd_first, 72);
    check("t2_ovr", ovr_first, -1);

    // Overrun on a left request merged behind a pending left job.
    quiesce();
    watch(110, 1, 5, 0, -1, -1);
    check("t3_ovr_first", ovr_first, 6);
    check("t3_rd_first", rd_first, 36);
    check("t3_ld_first", ld_first, 72);
    check("t3_ld_cnt", ld_cnt, 1);
    check("t3_l_mac_cnt", en_cnt - en_r_cnt, 32);

    // Abort mid-job, then a clean job afterwards.
    quiesce();
    watch(40, 0, -1, 2, 3, 15);
    check("t4_ovr_first", ovr_first, 4);
    check("t4_en15", en_at[15], 1);
    check("t4_en16", en_at[16], 0);
    check("t4_busy16", busy_at[16], 0);
    check("t4_ovr16", ovr_at[16], 0);
    check("t4_ld_cnt", ld_cnt, 0);
    check("t4_rd_cnt", rd_cnt, 0);
    watch(40, 0, -1, -1, -1, -1);
    check("t4b_ld_first", ld_first, 36);

    // N == 0: drain only.
    bus.coefs_per_tap = TW'(0);
    watch(10, 0, -1, -1, -1, -1);
    check("t5_en_cnt", en_cnt, 0);
    check("t5_ld_first", ld_first, 4);

    // Asynchronous reset in the middle of a right job.
    bus.coefs_per_tap = TW'(8);
    watch(13, -1, -1, 0, -1, -1);
    check("t6_en12", en_at[12], 1);
    check("t6_r_cnt", en_r_cnt, 11);
    #3 reset_n = 1'b0;
    #1;
    check_all_zero("areset");
    @(negedge clk); #2 reset_n = 1'b1;

    // N sweep extremes.
    bus.coefs_per_tap = TW'(1);
    watch(12, 0, -1, -1, -1, -1);
    check("t7_en_cnt", en_cnt, 4);
    check("t7_clr_cnt", clr_cnt, 4);
    check("t7_ld_first", ld_first, 8);
    bus.coefs_per_tap = TW'(511);
    watch(2052, 0, -1, -1, -1, -1);
    check("t8_en_cnt", en_cnt, 2044);
    check("t8_last_fsel", last_fsel, 3);
    check("t8_last_tap", last_tap, 510);
    check("t8_ld_first", ld_first, 2048);

    // Random traffic against the model; coefs_per_tap wiggles every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      bus.run   = ($urandom_range(0, 199) != 0);
      bus.l_req = ($urandom_range(0, 24) == 0);
      bus.r_req = ($urandom_range(0, 24) == 0);
      bus.coefs_per_tap = ($urandom_range(0, 9) == 0) ? TW'($urandom_range(0, 40))
                                                      : TW'($urandom_range(0, 6));
    end
    bus.l_req = 1'b0;
    bus.r_req = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
